// File: rtl/mips_muldiv_seq_if.sv
// Request/result bundle between the MIPS controller/datapath and the HI/LO
// multiply/divide sequencer.
interface mips_muldiv_seq_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] rs_val;
  logic [DATA_WIDTH-1:0] rt_val;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  div_zero;
  logic [DATA_WIDTH-1:0] hi_out;
  logic [DATA_WIDTH-1:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val, flush,
    input  busy, done, div_zero, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val, flush,
    output busy, done, div_zero, hi_out, lo_out
  );
endinterface

// File: rtl/mips_muldiv_seq.sv
// One-bit-per-cycle MULT/MULTU/DIV/DIVU engine feeding HI/LO. Operands are
// made unsigned on accept; signs are re-applied in a single SIGN cycle.
module mips_muldiv_seq #(
  parameter int DATA_WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_muldiv_seq_if.slave md_io
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t           state_q;
  logic [2*W-1:0]   acc_q;
  logic [W-1:0]     dvs_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;

  logic             signed_op;
  logic             rs_neg;
  logic             rt_neg;
  logic [W-1:0]     rs_abs;
  logic [W-1:0]     rt_abs;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next;
  logic [W-1:0]     div_diff;
  logic [2*W-1:0]   div_next;
  logic [2*W-1:0]   prod_signed;
  logic [W-1:0]     res_hi;
  logic [W-1:0]     res_lo;

  always_comb begin
    signed_op = ~md_io.op[0];
    rs_neg    = signed_op & md_io.rs_val[W-1];
    rt_neg    = signed_op & md_io.rt_val[W-1];
    rs_abs    = rs_neg ? (~md_io.rs_val + 1'b1) : md_io.rs_val;
    rt_abs    = rt_neg ? (~md_io.rt_val + 1'b1) : md_io.rt_val;

    // Multiply: LO half holds the remaining multiplier bits, shifted out LSB first.
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? dvs_q : {W{1'b0}})};
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Restoring divide: HI is the partial remainder, LO shifts dividend out / quotient in.
    div_diff = {acc_q[2*W-2:W], acc_q[W-1]} - dvs_q;
    if ({acc_q[2*W-1:W], acc_q[W-1]} >= {1'b0, dvs_q})
      div_next = {div_diff, acc_q[W-2:0], 1'b1};
    else
      div_next = {acc_q[2*W-2:0], 1'b0};

    prod_signed = neg_quo_q ? (~acc_q + 1'b1) : acc_q;
    if (is_div_q) begin
      res_hi = neg_rem_q ? (~acc_q[2*W-1:W] + 1'b1) : acc_q[2*W-1:W];
      res_lo = neg_quo_q ? (~acc_q[W-1:0] + 1'b1)   : acc_q[W-1:0];
    end else begin
      res_hi = prod_signed[2*W-1:W];
      res_lo = prod_signed[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (md_io.start && !md_io.flush) begin
            is_div_q <= md_io.op[1];
            busy_q   <= 1'b1;
            if (md_io.op[1] && (md_io.rt_val == '0)) begin
              hi_q    <= md_io.rs_val;
              lo_q    <= '1;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              acc_q     <= {{W{1'b0}}, rs_abs};
              dvs_q     <= rt_abs;
              neg_quo_q <= rs_neg ^ rt_neg;
              neg_rem_q <= rs_neg;
              cnt_q     <= CW'(W - 1);
              state_q   <= CALC;
            end
          end
        end
        CALC: begin
          if (md_io.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            acc_q <= is_div_q ? div_next : mul_next;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == '0)
              state_q <= SIGN;
          end
        end
        SIGN: begin
          if (md_io.flush) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          // Result already committed, so a flush here changes nothing.
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign md_io.busy     = busy_q;
  assign md_io.done     = done_q;
  assign md_io.div_zero = dz_q;
  assign md_io.hi_out   = hi_q;
  assign md_io.lo_out   = lo_q;
endmodule

// File: tb/tb_mips_muldiv_seq.sv
// Directed bench for mips_muldiv_seq: result values, latency, busy span,
// divide-by-zero, overflow, flush and async reset.
module tb_mips_muldiv_seq;
  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  mips_muldiv_seq_if #(.DATA_WIDTH(32)) md ();

  mips_muldiv_seq #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md_io (md.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start is driven in cycle t; lat counts cycles until the done pulse.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ehi, input logic [31:0] elo,
                       input logic edz, input int elat);
    int lat;
    int busy_cnt;
    @(negedge clk);
    md.start  = 1'b1;
    md.op     = op;
    md.rs_val = rs;
    md.rt_val = rt;
    lat       = 0;
    busy_cnt  = 0;
    while (lat < 100) begin
      @(negedge clk);
      md.start = 1'b0;
      lat++;
      if (md.busy) busy_cnt++;
      if (md.done) break;
    end
    chk({tag, "_lat"},  64'(lat), 64'(elat));
    chk({tag, "_busy"}, 64'(busy_cnt), 64'(elat));
    chk({tag, "_hi"},   64'(md.hi_out), 64'(ehi));
    chk({tag, "_lo"},   64'(md.lo_out), 64'(elo));
    chk({tag, "_dz"},   64'(md.div_zero), 64'(edz));
    $display("op=%0d rs=%h rt=%h lat=%0d hi=%h lo=%h dz=%0b", op, rs, rt, lat,
             md.hi_out, md.lo_out, md.div_zero);
  endtask

  initial begin
    int seen_done;
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    md.start  = 1'b0;
    md.op     = 2'b00;
    md.rs_val = '0;
    md.rt_val = '0;
    md.flush  = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(md.busy), 64'd0);
    chk("rst_done", 64'(md.done), 64'd0);
    chk("rst_hilo", {md.hi_out, md.lo_out}, 64'd0);
    rst_n = 1'b1;

    do_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 34);
    do_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 34);
    do_op("div_neg",   2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34);
    do_op("divu_100",  2'b11, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34);
    do_op("divu_zero", 2'b11, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 1);
    do_op("div_ovf",   2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34);
    do_op("multu_3x4", 2'b01, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 34);

    // Flush in cycle t+10 of a MULTU: busy drops at t+11, result registers hold.
    @(negedge clk);
    md.start  = 1'b1;
    md.op     = 2'b01;
    md.rs_val = 32'd9;
    md.rt_val = 32'd9;
    seen_done = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      md.start = 1'b0;
      if (md.done) seen_done++;
    end
    md.flush = 1'b1;
    @(negedge clk);
    md.flush = 1'b0;
    chk("flush_busy", 64'(md.busy), 64'd0);
    for (int i = 0; i < 40; i++) begin
      if (md.done) seen_done++;
      @(negedge clk);
    end
    chk("flush_nodone", 64'(seen_done), 64'd0);
    chk("flush_hilo", {md.hi_out, md.lo_out}, 64'h00000000_0000000C);
    $display("flush mid-calc hi=%h lo=%h busy=%0b", md.hi_out, md.lo_out, md.busy);

    // start and flush together in IDLE: request dropped.
    md.start  = 1'b1;
    md.flush  = 1'b1;
    md.rs_val = 32'd5;
    @(negedge clk);
    md.start = 1'b0;
    md.flush = 1'b0;
    chk("startflush_busy", 64'(md.busy), 64'd0);
    $display("start+flush busy=%0b", md.busy);

    // Async reset mid-CALC clears outputs without waiting for a clock edge.
    md.start  = 1'b1;
    md.op     = 2'b01;
    md.rs_val = 32'd7;
    md.rt_val = 32'd7;
    @(negedge clk);
    md.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("precalc_busy", 64'(md.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(md.busy), 64'd0);
    chk("arst_hilo", {md.hi_out, md.lo_out}, 64'd0);
    chk("arst_dz", {63'd0, md.done | md.div_zero}, 64'd0);
    $display("async reset busy=%0b hi=%h lo=%h", md.busy, md.hi_out, md.lo_out);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("multu_2x3", 2'b01, 32'd2, 32'd3, 32'h00000000, 32'h00000006, 1'b0, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
